module_hamming_arbiter: RTL and testbench
=========================================

# module_hamming_arbiter

Sequencer and arbiter that shares one Hamming(7,4) syndrome/correct/decode datapath between two word sources: requester 0 is the locally encoded word (switch path) and requester 1 is the externally received word. It takes one 7-bit word at a time through a fixed three-stage sequence and returns a decoded 4-bit nibble plus syndrome and error flag over a valid/ready handshake. It also keeps per-source corrected-error counters. It sits between the encoder/input switches and the LED, 7-segment and error-display drivers.

## Interface
- CNT_W, 8, width of each per-source error counter
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-requester word valid; bit i = requester i
- req_word  in  14  {word1, word0}; 7 bits each, bit 0 = Hamming position 1
- req_ready  out  2  one-hot, one-cycle accept pulse to the granted requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_data  out  4  decoded nibble {d4,d3,d2,d1} = {w[6],w[5],w[4],w[2]} of the corrected word
- rsp_syndrome  out  3  {s4,s2,s1}
- rsp_err  out  1  syndrome nonzero
- err_clr  in  1  clears both counters
- err_count  out  2*CNT_W  {cnt1, cnt0}, saturating
- busy  out  1  FSM not in IDLE

## Operation
- Word layout, positions 1..7: p1 p2 d1 p4 d2 d3 d4, mapped to w[0]..w[6].
- Syndrome bits:
  - s1 = w0^w2^w4^w6
  - s2 = w1^w2^w5^w6
  - s4 = w3^w4^w5^w6
- Correction: if s != 0, invert w[s-1]. Double-bit errors miscorrect silently; this is accepted behaviour.
- FSM states: IDLE, SYND, CORR, RESP.
  - IDLE: if any req_valid, grant one requester, pulse its req_ready, latch its word into a holding register, go to SYND. Otherwise stay.
  - SYND: register the syndrome of the held word, go to CORR.
  - CORR: register the corrected word, decoded nibble and err flag, go to RESP.
  - RESP: hold rsp_valid=1 with all rsp_* stable until rsp_ready=1. On that handshake cycle go to IDLE.
- Arbitration: round-robin.
  - last_grant register resets to 1, so requester 0 wins the first conflict.
  - When both requesters are valid, grant the one that is not last_grant.
  - When only one is valid, grant it.
  - last_grant updates on the grant.
- Requests are accepted only in IDLE. A requester whose req_valid drops before it is granted is simply not served; no queueing.
- Counters: on the CORR→RESP transition, if s != 0, increment cnt[rsp_id]. Saturate at 2^CNT_W−1.
  - err_clr zeroes both counters.
  - err_clr wins over a simultaneous increment.
- Reset values: rsp_valid=0, req_ready=0, rsp_id=0, rsp_data=0, rsp_syndrome=0, rsp_err=0, err_count=0, busy=0, state=IDLE, last_grant=1.
- Reset mid-operation: the held word is discarded, with no response and no counter update.

## Timing
- Grant and req_ready pulse are in cycle T, and the word is sampled at the end of T.
- rsp_valid rises at T+3.
- Throughput with rsp_ready tied high: one word per 4 cycles. The next grant is possible in the cycle after the RESP handshake.
- req_ready is high exactly one cycle per accepted word and never to both requesters.
- rsp_* change only on entry to RESP. They hold their last values in IDLE, SYND and CORR, with rsp_valid=0 there.
- busy is high from T+1 through the RESP handshake cycle.
- err_count is updated on the same edge that asserts rsp_valid.

## Structure
- Package hamming_pkg holds:
  - the state enum (IDLE, SYND, CORR, RESP);
  - DATA_W=4, WORD_W=7, SYN_W=3;
  - the data-position constants {6,5,4,2}.
- Sub-module module_hamming_corrector: purely combinational, word in, syndrome and corrected word out. It is instantiated once and is the shared resource.
- The FSM, arbiter and counters live in the top of this block.

## Test plan
- Reset, then req_valid=01, word0=7'h55 (data 1011, clean) -> req_ready=01 at T; at T+3 rsp_valid=1, rsp_id=0, rsp_data=4'hB, rsp_syndrome=0, rsp_err=0; cnt0 stays 0.
- req_valid=10, word1=7'h45 (7'h55 with position 5 flipped) -> rsp_syndrome=3'b101, rsp_err=1, rsp_data=4'hB, rsp_id=1; cnt1 becomes 1.
- Both req_valid=11 held for three transactions after reset -> grants in order 0, 1, 0; req_ready is never 11.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, busy=1, no req_ready pulses. Raise rsp_ready -> IDLE next cycle, new grant in the following IDLE cycle.
- 260 errored words on requester 0 -> cnt0 saturates at 255. Then err_clr asserted in the same cycle as an increment -> cnt0=0.
- rst asserted in CORR -> next cycle state IDLE, all outputs at reset values, no response for the dropped word.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared constants, state encoding and the data-extraction
//                helper for the Hamming(7,4) sequencer/arbiter slice.
//
//                Word layout (bit index = Hamming position - 1):
//                  w[0]=p1 w[1]=p2 w[2]=d1 w[3]=p4 w[4]=d2 w[5]=d3 w[6]=d4
//  Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int WORD_W = 7;
  localparam int SYN_W  = 3;

  // Sequencer states. Two bits cover the four states exactly.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SYND = 2'd1;
  localparam state_t ST_CORR = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Word bit positions of the data bits, packed as {d4,d3,d2,d1} = {6,5,4,2}.
  // Field i (3 bits wide) holds the word index of data bit d(i+1).
  localparam logic [3*DATA_W-1:0] DATA_POS = {3'd6, 3'd5, 3'd4, 3'd2};

  // Gather the four data bits of a (corrected) codeword into a nibble.
  function automatic logic [DATA_W-1:0] extract_data(input logic [WORD_W-1:0] word);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = word[DATA_POS[3*i +: 3]];
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/module_hamming_corrector.sv
`default_nettype none
// ============================================================================
//  Module      : module_hamming_corrector
//  Description : Purely combinational Hamming(7,4) syndrome generator and
//                single-bit corrector. This is the one datapath shared by
//                both requesters of module_hamming_arbiter.
//
//  Ports
//    word      in  7  received codeword, bit 0 = position 1
//    syndrome  out 3  {s4,s2,s1}; nonzero value = position of the bad bit
//    corrected out 7  word with bit (syndrome-1) inverted when syndrome != 0
//
//  Double-bit errors produce a nonzero syndrome that points at the wrong
//  bit; the word is then miscorrected silently.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_hamming_corrector
  import hamming_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [SYN_W-1:0]  syndrome,
  output logic [WORD_W-1:0] corrected
);

  logic [WORD_W-1:0] flip_mask;

  always_comb begin
    syndrome    = '0;
    syndrome[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
    syndrome[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
    syndrome[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
  end

  // One-hot flip mask: bit k is set when the syndrome names position k+1.
  // A zero syndrome matches no position, so a clean word passes untouched.
  generate
    for (genvar k = 0; k < WORD_W; k++) begin : g_flip
      assign flip_mask[k] = (syndrome == SYN_W'(k + 1));
    end
  endgenerate

  assign corrected = word ^ flip_mask;

endmodule
`default_nettype wire

// File: rtl/module_hamming_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : module_hamming_arbiter
//  Description : Round-robin arbiter and 4-state sequencer (IDLE, SYND, CORR,
//                RESP) that time-shares a single Hamming(7,4) corrector
//                between the locally encoded word (requester 0) and the
//                externally received word (requester 1). Keeps a saturating
//                corrected-error counter per requester.
//
//  Ports
//    clk           in  1        system clock, rising edge
//    rst           in  1        synchronous active-high reset
//    req_valid     in  2        bit i = requester i has a word
//    req_word      in  14       {word1, word0}
//    req_ready     out 2        one-hot accept pulse in the grant cycle
//    rsp_valid     out 1        result valid (RESP state)
//    rsp_ready     in  1        consumer accepts result
//    rsp_id        out 1        requester owning the result
//    rsp_data      out 4        decoded nibble {d4,d3,d2,d1}
//    rsp_syndrome  out 3        {s4,s2,s1}
//    rsp_err       out 1        syndrome nonzero
//    err_clr       in  1        clears both counters (wins over increment)
//    err_count     out 2*CNT_W  {cnt1, cnt0}, saturating
//    busy          out 1        sequencer not in IDLE
//
//  Timing: grant in cycle T, word captured at the end of T, rsp_valid at
//  T+3, next grant possible the cycle after the RESP handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_hamming_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*WORD_W-1:0] req_word,
  output logic [1:0]          req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [SYN_W-1:0]    rsp_syndrome,
  output logic                rsp_err,
  input  logic                err_clr,
  output logic [2*CNT_W-1:0]  err_count,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic                last_grant;
  logic [WORD_W-1:0]   held_word;
  logic                held_id;
  logic [SYN_W-1:0]    syn_q;

  logic                grant_any;
  logic                grant_id;
  logic [SYN_W-1:0]    corr_syndrome;
  logic [WORD_W-1:0]   corr_word;
  logic                bump;

  // --------------------------------------------------------------------------
  // Round-robin grant. Only evaluated in IDLE; gated by rst so that no accept
  // pulse can leak out while the block is being reset.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst && state == ST_IDLE && req_valid != 2'b00) begin
      grant_any = 1'b1;
      if (req_valid == 2'b11) begin
        grant_id = ~last_grant;
      end else begin
        grant_id = req_valid[1];
      end
    end
  end

  assign req_ready = {grant_any & grant_id, grant_any & ~grant_id};
  assign busy      = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Shared correction datapath, always fed from the holding register.
  // --------------------------------------------------------------------------
  module_hamming_corrector u_corrector (
    .word      (held_word),
    .syndrome  (corr_syndrome),
    .corrected (corr_word)
  );

  // --------------------------------------------------------------------------
  // Sequencer. rsp_* are loaded only on the CORR->RESP edge and otherwise
  // keep their last values, so the consumer sees stable data throughout RESP.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      held_word    <= '0;
      held_id      <= 1'b0;
      syn_q        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_syndrome <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            held_word  <= grant_id ? req_word[2*WORD_W-1:WORD_W] : req_word[WORD_W-1:0];
            held_id    <= grant_id;
            last_grant <= grant_id;
            state      <= ST_SYND;
          end
        end
        ST_SYND: begin
          syn_q <= corr_syndrome;
          state <= ST_CORR;
        end
        ST_CORR: begin
          rsp_data     <= extract_data(corr_word);
          rsp_syndrome <= syn_q;
          rsp_err      <= (syn_q != '0);
          rsp_id       <= held_id;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Corrected-error counters. The increment lands on the same edge that
  // raises rsp_valid; err_clr takes priority over that increment.
  // --------------------------------------------------------------------------
  assign bump = (state == ST_CORR) && (syn_q != '0);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || err_clr) begin
          cnt <= '0;
        end else if (bump && held_id == 1'(i) && cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign err_count[i*CNT_W +: CNT_W] = cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_module_hamming_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_module_hamming_arbiter
//  Description : Self-checking bench for module_hamming_arbiter. A
//                transaction-level model predicts every output each cycle;
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_module_hamming_arbiter;

  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [13:0] req_word = '0;
  logic        rsp_ready = 1'b1;
  logic        err_clr = 1'b0;

  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [3:0]  rsp_data;
  logic [2:0]  rsp_syndrome;
  logic        rsp_err;
  logic [15:0] err_count;
  logic        busy;

  module_hamming_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_word     (req_word),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_syndrome (rsp_syndrome),
    .rsp_err      (rsp_err),
    .err_clr      (err_clr),
    .err_count    (err_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model.
  // phase: 0 = waiting for a grant, 1..2 = latency cycles, 3 = presenting.
  // --------------------------------------------------------------------------
  int         m_phase = 0;
  logic       m_lg = 1'b1;
  logic       m_id = 1'b0;
  logic [6:0] m_word = '0;
  logic       e_id = 1'b0;
  logic [3:0] e_data = '0;
  logic [2:0] e_syn = '0;
  logic       e_err = 1'b0;
  int         m_cnt [2] = '{0, 0};
  bit         live = 1'b0;
  int         grants [$];

  // Classic Hamming definition: syndrome = XOR of the positions of all 1 bits.
  function automatic int model_syndrome(input logic [6:0] w);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) begin
      if (w[p-1]) s = s ^ p;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    logic [1:0] e_rr;
    logic [6:0] cw;
    int         s;
    if (rst) live = 1'b1;
    if (live) begin
      e_rr = 2'b00;
      if (!rst && m_phase == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) e_rr = m_lg ? 2'b01 : 2'b10;
        else                    e_rr = req_valid;
      end
      check("req_ready", 32'(req_ready), 32'(e_rr));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 3));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("rsp_id", 32'(rsp_id), 32'(e_id));
      check("rsp_data", 32'(rsp_data), 32'(e_data));
      check("rsp_syndrome", 32'(rsp_syndrome), 32'(e_syn));
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("err_count", 32'(err_count), {16'h0, m_cnt[1][7:0], m_cnt[0][7:0]});
      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));

      if (rst) begin
        m_phase = 0; m_lg = 1'b1; e_id = 1'b0; e_data = '0; e_syn = '0; e_err = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
        case (m_phase)
          0: if (e_rr != 2'b00) begin
               m_id    = e_rr[1];
               m_lg    = e_rr[1];
               m_word  = m_id ? req_word[13:7] : req_word[6:0];
               m_phase = 1;
             end
          1: m_phase = 2;
          2: begin
               s  = model_syndrome(m_word);
               cw = m_word;
               if (s != 0) cw[s-1] = ~cw[s-1];
               e_data = {cw[6], cw[5], cw[4], cw[2]};
               e_syn  = s[2:0];
               e_err  = (s != 0);
               e_id   = m_id;
               if (s != 0 && m_cnt[m_id] < 255) m_cnt[m_id] = m_cnt[m_id] + 1;
               m_phase = 3;
             end
          default: if (rsp_ready) m_phase = 0;
        endcase
        if (err_clr) begin
          m_cnt[0] = 0;
          m_cnt[1] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One errored word on requester 0 with err_clr asserted during CORR.
  task automatic err_clr_round(input string tag);
    req_word  = {7'h00, 7'h54};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd1);
    check({tag, " err_count"}, 32'(err_count), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) tick();
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- clean word on requester 0 ----------------
    req_word  = {7'h00, 7'h55};
    req_valid = 2'b01;
    #1;
    check("t1 req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("t1 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1 rsp_id", 32'(rsp_id), 32'd0);
    check("t1 rsp_data", 32'(rsp_data), 32'hB);
    check("t1 rsp_syndrome", 32'(rsp_syndrome), 32'd0);
    check("t1 rsp_err", 32'(rsp_err), 32'd0);
    check("t1 err_count", 32'(err_count), 32'd0);
    tick();

    // ---------------- position-5 error on requester 1 ----------------
    req_word  = {7'h45, 7'h00};
    req_valid = 2'b10;
    #1;
    check("t2 req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("t2 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2 rsp_id", 32'(rsp_id), 32'd1);
    check("t2 rsp_data", 32'(rsp_data), 32'hB);
    check("t2 rsp_syndrome", 32'(rsp_syndrome), 32'd5);
    check("t2 rsp_err", 32'(rsp_err), 32'd1);
    check("t2 err_count", 32'(err_count), 32'h0100);
    tick();

    // ---------------- round robin with both requesting ----------------
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    grants.delete();
    req_word  = {7'h45, 7'h55};
    req_valid = 2'b11;
    repeat (12) tick();
    req_valid = 2'b00;
    check("rr grant count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      check("rr grant 0", 32'(grants[0]), 32'd0);
      check("rr grant 1", 32'(grants[1]), 32'd1);
      check("rr grant 2", 32'(grants[2]), 32'd0);
    end
    tick();

    // ---------------- backpressure in RESP ----------------
    rsp_ready = 1'b0;
    req_word  = {7'h00, 7'h54};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp busy", 32'(busy), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp rsp_data", 32'(rsp_data), 32'hB);
      check("bp rsp_syndrome", 32'(rsp_syndrome), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp handshake req_ready", 32'(req_ready), 32'd0);
    tick();
    check("bp idle busy", 32'(busy), 32'd0);
    check("bp next grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    // ---------------- saturation of cnt0 ----------------
    req_word  = {7'h00, 7'h54};
    req_valid = 2'b01;
    repeat (4 * 259 + 1) tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("sat rsp_valid", 32'(rsp_valid), 32'd1);
    check("sat cnt0", 32'(err_count[7:0]), 32'd255);
    tick();

    // ---------------- err_clr against a simultaneous increment ----------------
    err_clr_round("clr sat");
    err_clr_round("clr fresh");

    // ---------------- reset in CORR ----------------
    req_word  = {7'h45, 7'h00};
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    check("rc rsp_valid", 32'(rsp_valid), 32'd0);
    check("rc busy", 32'(busy), 32'd0);
    check("rc req_ready", 32'(req_ready), 32'd0);
    check("rc rsp_data", 32'(rsp_data), 32'd0);
    check("rc rsp_syndrome", 32'(rsp_syndrome), 32'd0);
    check("rc rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rc no response", 32'(rsp_valid), 32'd0);
    end
    check("rc err_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
